// File: rtl/pipe_stage_reg.sv
// Two-entry skid pipeline stage (main + skid, strict FIFO) with synchronous flush; data latency 1 cycle.
// in_ready is decoded from the state register only, so it never depends combinationally on out_ready.
module pipe_stage_reg #(
   parameter int PAYLOAD_W      = 81,
   parameter bit CLEAR_ON_FLUSH = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [PAYLOAD_W-1:0] in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [PAYLOAD_W-1:0] out_data,
   input  logic                 flush,
   output logic [1:0]           occupancy
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [PAYLOAD_W-1:0] main_q, main_d;
   logic [PAYLOAD_W-1:0] skid_q, skid_d;
   logic                 accept;
   logic                 pop;

   assign accept = in_valid & in_ready;
   assign pop    = out_valid & out_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

   // Flush wins over everything; draining to EMPTY zeroes main so out_data reads 0 when idle.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = EMPTY;
         if (CLEAR_ON_FLUSH) begin
            main_d = '0;
            skid_d = '0;
         end
      end else begin
         unique case (state_q)
            EMPTY: begin
               if (accept) begin
                  state_d = ONE;
                  main_d  = in_data;
               end
            end
            ONE: begin
               if (accept && pop) begin
                  main_d = in_data;
               end else if (accept) begin
                  state_d = FULL;
                  skid_d  = in_data;
               end else if (pop) begin
                  state_d = EMPTY;
                  main_d  = '0;
               end
            end
            FULL: begin
               if (pop) begin
                  state_d = ONE;
                  main_d  = skid_q;
                  skid_d  = '0;
               end
            end
            default: begin
               state_d = EMPTY;
            end
         endcase
      end
   end

   always_comb begin
      out_valid = (state_q != EMPTY);
      in_ready  = (state_q != FULL);
      occupancy = state_q;
   end

   assign out_data = main_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed checks of pipe_stage_reg (reset, latency, backpressure, flush, async reset)
// followed by random valid/ready/flush traffic against a queue reference.
module tb_pipe_stage_reg;

   localparam int W = 81;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_data = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] out_data;
   logic         flush = 1'b0;
   logic [1:0]   occupancy;

   int checks = 0;
   int errors = 0;

   pipe_stage_reg #(.PAYLOAD_W(W), .CLEAR_ON_FLUSH(1'b1)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .flush     (flush),
      .occupancy (occupancy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_state(input string tag, input logic vld, input logic rdy,
                            input logic [1:0] occ, input logic [W-1:0] dat);
      chk({tag, ".vld"}, 128'(out_valid), 128'(vld));
      chk({tag, ".rdy"}, 128'(in_ready), 128'(rdy));
      chk({tag, ".occ"}, 128'(occupancy), 128'(occ));
      chk({tag, ".dat"}, 128'(out_data), 128'(dat));
   endtask

   task automatic push(input logic [W-1:0] d);
      in_valid = 1'b1;
      in_data  = d;
      tick();
      in_valid = 1'b0;
   endtask

   logic [W-1:0] q[$];
   logic [W-1:0] rnd;
   logic [W-1:0] exp_dat;
   logic         acc, pp;

   initial begin
      // reset state, before any clock edge
      #2;
      chk_state("rst_async", 1'b0, 1'b1, 2'd0, '0);
      tick();
      tick();
      chk_state("rst_hold", 1'b0, 1'b1, 2'd0, '0);
      rst = 1'b1;
      tick();
      chk_state("rst_release", 1'b0, 1'b1, 2'd0, '0);

      // single transfer, latency 1
      out_ready = 1'b1;
      push(W'('h0A5));
      chk_state("single_1", 1'b1, 1'b1, 2'd1, W'('h0A5));
      tick();
      chk_state("single_2", 1'b0, 1'b1, 2'd0, '0);

      // back-to-back stream at full throughput
      for (int i = 1; i <= 4; i++) begin
         in_valid = 1'b1;
         in_data  = W'(i);
         chk("stream_rdy", 128'(in_ready), 128'(1));
         tick();
         chk("stream_vld", 128'(out_valid), 128'(1));
         chk("stream_dat", 128'(out_data), 128'(i));
         chk("stream_occ", 128'(occupancy), 128'(1));
      end
      in_valid = 1'b0;
      tick();
      chk_state("stream_end", 1'b0, 1'b1, 2'd0, '0);

      // backpressure: fill, ignore third value, drain in order
      out_ready = 1'b0;
      push(W'('h11));
      chk_state("bp_one", 1'b1, 1'b1, 2'd1, W'('h11));
      push(W'('h22));
      chk_state("bp_full", 1'b1, 1'b0, 2'd2, W'('h11));
      in_valid = 1'b1;
      in_data  = W'('h33);
      tick();
      chk_state("bp_stall", 1'b1, 1'b0, 2'd2, W'('h11));
      out_ready = 1'b1;
      tick();
      chk_state("bp_pop1", 1'b1, 1'b1, 2'd1, W'('h22));
      tick();
      chk_state("bp_pop2", 1'b1, 1'b1, 2'd1, W'('h33));
      in_valid = 1'b0;
      tick();
      chk_state("bp_empty", 1'b0, 1'b1, 2'd0, '0);

      // flush while FULL with a pop requested
      out_ready = 1'b0;
      push(W'('h11));
      push(W'('h22));
      chk_state("fl_full", 1'b1, 1'b0, 2'd2, W'('h11));
      flush     = 1'b1;
      out_ready = 1'b1;
      tick();
      flush = 1'b0;
      chk_state("fl_after", 1'b0, 1'b1, 2'd0, '0);
      tick();
      chk_state("fl_quiet", 1'b0, 1'b1, 2'd0, '0);

      // flush discards a simultaneous accept
      flush    = 1'b1;
      in_valid = 1'b1;
      in_data  = W'('h44);
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      chk_state("fl_acc", 1'b0, 1'b1, 2'd0, '0);

      // async reset between edges while ONE
      out_ready = 1'b0;
      push(W'('h5));
      chk_state("ar_one", 1'b1, 1'b1, 2'd1, W'('h5));
      #2;
      rst = 1'b0;
      #1;
      chk_state("ar_now", 1'b0, 1'b1, 2'd0, '0);
      #2;
      rst = 1'b1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = W'('h7);
      tick();
      in_valid = 1'b0;
      chk_state("ar_push", 1'b1, 1'b1, 2'd1, W'('h7));
      tick();
      chk_state("ar_drain", 1'b0, 1'b1, 2'd0, '0);

      // random traffic against a queue reference model
      q.delete();
      for (int c = 0; c < 10000; c++) begin
         rnd       = W'({$urandom(), $urandom(), $urandom()});
         in_valid  = ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 9) < 6);
         flush     = ($urandom_range(0, 19) == 0);
         in_data   = rnd;
         acc = in_valid && (q.size() < 2);
         pp  = out_ready && (q.size() > 0);
         tick();
         if (flush) begin
            q.delete();
         end else begin
            if (pp) void'(q.pop_front());
            if (acc) q.push_back(rnd);
         end
         exp_dat = (q.size() > 0) ? q[0] : '0;
         chk("rand", 128'({occupancy, in_ready, out_valid, out_data}),
             128'({2'(q.size()), (q.size() < 2), (q.size() > 0), exp_dat}));
      end
      in_valid = 1'b0;
      flush    = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter PAYLOAD_W, default 81, SHALL set the width of the payload carried between stages (any value >= 1).
REQ-002 Parameter CLEAR_ON_FLUSH, default 1, SHALL select whether flush zeroes stored payload (1) or only drops valid (0).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 in_valid  input  1  SHALL mean the upstream stage presents a payload.
REQ-006 in_ready  output  1  SHALL mean the block accepts a payload this cycle.
REQ-007 in_data  input  PAYLOAD_W  SHALL be the upstream payload.
REQ-008 out_valid  output  1  SHALL mean out_data holds a valid payload.
REQ-009 out_ready  input  1  SHALL mean the downstream stage consumes out_data this cycle.
REQ-010 out_data  output  PAYLOAD_W  SHALL be the downstream payload.
REQ-011 flush  input  1  SHALL be a synchronous pipeline flush (branch or exception kill).
REQ-012 occupancy  output  2  SHALL report the number of stored entries (0..2).

Function
REQ-013 Storage SHALL be two entries: main (drives out_data) and skid; the order SHALL be strict FIFO.
REQ-014 States SHALL be EMPTY (0 entries), ONE (main only), FULL (main and skid); occupancy SHALL equal 0/1/2 respectively.
REQ-015 in_ready SHALL be a registered signal equal to 1 in EMPTY and ONE and 0 in FULL, with no combinational path from out_ready.
REQ-016 Accept SHALL occur when in_valid and in_ready are both 1; pop SHALL occur when out_valid and out_ready are both 1.
REQ-017 out_valid SHALL be 1 exactly in ONE and FULL.
REQ-018 EMPTY + accept -> ONE; the payload SHALL appear on out_data one cycle after accept (latency 1).
REQ-019 ONE + accept + pop -> ONE; main SHALL load in_data (throughput 1 per cycle).
REQ-020 ONE + accept, no pop -> FULL; skid SHALL load in_data and main SHALL hold.
REQ-021 ONE + pop, no accept -> EMPTY.
REQ-022 FULL + pop -> ONE; main SHALL load skid. No accept is possible in FULL.
REQ-023 While out_valid=1 and out_ready=0, out_data and out_valid SHALL hold stable.
REQ-024 flush=1 SHALL override all other events: the next state SHALL be EMPTY, any accept or pop in that cycle SHALL be discarded, and in_ready SHALL be 1 on the following cycle.
REQ-025 With CLEAR_ON_FLUSH=1, flush SHALL zero both entries; with 0, the entries SHALL retain stale data while out_valid=0.
REQ-026 In EMPTY, out_data SHALL be all zeros unless CLEAR_ON_FLUSH=0 and stale data remains.
REQ-027 in_data SHALL be sampled only on accept; in_data values while in_ready=0 SHALL be ignored.

Reset
REQ-028 rst=0 SHALL immediately force: state EMPTY, out_valid=0, out_data=0, skid=0, occupancy=0, in_ready=1.
REQ-029 Reset asserted mid-transfer SHALL discard all stored entries; the first edge after release SHALL be able to accept.
REQ-030 Reset release SHALL produce no spurious out_valid pulse.

Verification
REQ-031 Reset, then in_valid=1 with in_data=0x0A5 for one cycle, out_ready=1 -> out_valid=1 with out_data=0x0A5 on the next cycle only, occupancy 1 then 0.
REQ-032 Stream 0x1,0x2,0x3,0x4 on consecutive cycles with out_ready=1 -> the same values exit on consecutive cycles, in_ready held at 1.
REQ-033 out_ready=0, push 0x11 then 0x22 -> occupancy=2 and in_ready=0; third value 0x33 held on in_data is not taken; raise out_ready -> the outputs are 0x11, 0x22, 0x33 in order.
REQ-034 FULL with 0x11/0x22, assert flush together with out_ready=1 -> next cycle out_valid=0, occupancy=0, out_data=0 (CLEAR_ON_FLUSH=1), in_ready=1, and neither value is ever delivered.
REQ-035 Drop rst asynchronously between edges while in ONE -> outputs are zero at once, before the next edge; after release, push 0x7 -> 0x7 is delivered with latency 1.
REQ-036 Random valid/ready/flush traffic for 10k cycles against a scoreboard -> no loss, no duplicate, no reorder outside flushes, and occupancy matches the reference count.
